md_hazard_ctrl: RTL and testbench

- D-stage hazard/stall controller sitting directly downstream of mult_and_div; consumes its busy and start_look outputs.
- Decides when an HI/LO-class instruction in D must stall while the multiplier/divider is starting or busy.
- Tracks the unit's occupancy with a small FSM and a busy-length watchdog.
- Drives stall (hold PC and F/D register) and flush_E (bubble into the E register).

---
 rtl/md_hazard_ctrl_pkg.sv | 21 ++
 rtl/md_hazard_ctrl_decode.sv | 24 ++
 rtl/md_hazard_ctrl.sv | 91 +++++++++
 tb/tb_md_hazard_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/md_hazard_ctrl_pkg.sv
// Shared decode constants and MD occupancy state encodings for the HI/LO hazard logic;
// also consumed by the mult_and_div decoder.
package md_hazard_ctrl_pkg;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        MD_IDLE   = 2'd0,
        MD_ISSUED = 2'd1,
        MD_BUSY   = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_hazard_ctrl_decode.sv
// Flags instructions that read or write HI/LO or launch a mult/div operation.
module md_class_decode
    import md_hazard_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_md
);

    // rs/rt/rd/shamt do not affect the class
    logic unused_fields;
    assign unused_fields = ^instr[25:6];

    always_comb begin
        is_md = 1'b0;
        if (instr[31:26] == OP_SPECIAL) begin
            case (instr[5:0])
                FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
                FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: is_md = 1'b1;
                default: is_md = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/md_hazard_ctrl.sv
// D-stage stall/flush controller for HI/LO-class instructions behind mult_and_div.
// Define MD_HAZARD_STATS_EN to add the stall_cycles / md_ops counters.
module md_hazard_ctrl
    import md_hazard_ctrl_pkg::*;
#(
    parameter int MAX_BUSY = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_D,
    input  logic        md_start,
    input  logic        md_busy,
    output logic        stall,
    output logic        flush_E,
    output logic [1:0]  md_state,
`ifdef MD_HAZARD_STATS_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] md_ops,
`endif
    output logic        md_timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] BUSY_LIMIT = CNT_W'(MAX_BUSY);

    logic             is_md;
    md_state_e        state, state_next;
    logic [CNT_W-1:0] busy_cnt, busy_cnt_next;
    logic             timeout_q;

    md_class_decode u_decode (
        .instr (Instr_D),
        .is_md (is_md)
    );

    // ISSUED bridges the single cycle between start and busy rising
    assign stall      = reset && is_md && (md_start || md_busy || state == MD_ISSUED);
    assign flush_E    = stall;
    assign md_state   = state;
    assign md_timeout = timeout_q;

    always_comb begin
        state_next = MD_IDLE;
        case (state)
            MD_IDLE, MD_ISSUED, MD_BUSY: begin
                if (md_busy)       state_next = MD_BUSY;
                else if (md_start) state_next = MD_ISSUED;
                else               state_next = MD_IDLE;
            end
            default: state_next = MD_IDLE;
        endcase
    end

    always_comb begin
        busy_cnt_next = '0;
        if (state == MD_BUSY && state_next == MD_BUSY)
            busy_cnt_next = (busy_cnt == CNT_MAX) ? busy_cnt : busy_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= MD_IDLE;
            busy_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state    <= state_next;
            busy_cnt <= busy_cnt_next;
            if (busy_cnt_next > BUSY_LIMIT)
                timeout_q <= 1'b1;
        end
    end

`ifdef MD_HAZARD_STATS_EN
    logic op_launch;
    assign op_launch = (state_next == MD_ISSUED) && (state != MD_ISSUED);

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles <= '0;
            md_ops       <= '0;
        end else begin
            if (stall && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
            if (op_launch && md_ops != 32'hFFFF_FFFF)
                md_ops <= md_ops + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// Scoreboard bench for md_hazard_ctrl: the driver queues hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_md_hazard_ctrl;

    localparam logic [31:0] I_MFHI = 32'h0000_5010;
    localparam logic [31:0] I_MFLO = 32'h0000_5012;
    localparam logic [31:0] I_MULT = 32'h0109_0018;
    localparam logic [31:0] I_DIV  = 32'h0109_001A;
    localparam logic [31:0] I_ADD  = 32'h0109_5020;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Instr_D = '0;
    logic        md_start = 1'b0;
    logic        md_busy = 1'b0;
    logic        stall, flush_E, md_timeout;
    logic [1:0]  md_state;
`ifdef MD_HAZARD_STATS_EN
    logic [31:0] stall_cycles, md_ops;
`endif

    md_hazard_ctrl #(.MAX_BUSY(16), .CNT_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .Instr_D      (Instr_D),
        .md_start     (md_start),
        .md_busy      (md_busy),
        .stall        (stall),
        .flush_E      (flush_E),
        .md_state     (md_state),
`ifdef MD_HAZARD_STATS_EN
        .stall_cycles (stall_cycles),
        .md_ops       (md_ops),
`endif
        .md_timeout   (md_timeout)
    );

    always #5 clk = ~clk;

    // -1 in any field means "not checked this cycle"
    typedef struct {
        string name;
        int    stall;
        int    state;
        int    to;
        int    sc;
        int    ops;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    exp_t e;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.stall >= 0) begin
                check({e.name, " stall"},   int'(stall),   e.stall);
                check({e.name, " flush_E"}, int'(flush_E), e.stall);
            end
            if (e.state >= 0) check({e.name, " md_state"},   int'(md_state),   e.state);
            if (e.to >= 0)    check({e.name, " md_timeout"}, int'(md_timeout), e.to);
`ifdef MD_HAZARD_STATS_EN
            if (e.sc >= 0)    check({e.name, " stall_cycles"}, int'(stall_cycles), e.sc);
            if (e.ops >= 0)   check({e.name, " md_ops"},       int'(md_ops),       e.ops);
`endif
        end
    end

    // Inputs change just after the edge; expectations describe the cycle that follows.
    task automatic step(input string name, input int rst, input logic [31:0] instr,
                        input int st, input int bz, input int e_stall, input int e_state,
                        input int e_to, input int e_sc = -1, input int e_ops = -1);
        exp_t x;
        @(posedge clk);
        #1;
        reset    = 1'(rst);
        Instr_D  = instr;
        md_start = 1'(st);
        md_busy  = 1'(bz);
        x.name = name; x.stall = e_stall; x.state = e_state; x.to = e_to;
        x.sc = e_sc; x.ops = e_ops;
        q.push_back(x);
    endtask

    initial begin
        // reset holds stall low even with busy/start and an MD instruction in D
        step("rst0", 0, I_MFHI, 1, 1, 0, 0, 0);
        step("rst1", 0, I_MFHI, 0, 1, 0, 0, 0);
        step("idle", 1, I_MFHI, 0, 0, 0, 0, 0);

        step("gap0", 1, I_MFHI, 1, 0, 1, 0, 0);
        step("gap1", 1, I_MFHI, 0, 0, 1, 1, 0);
        step("gap2", 1, I_MFHI, 0, 0, 0, 0, 0);

        step("bs_start", 1, I_MULT, 1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++)
            step("bs_busy", 1, I_MULT, 0, 1, 1, (i == 0) ? 1 : 2, 0);
        step("bs_drop", 1, I_MULT, 0, 0, 0, 2, 0);
        step("bs_idle", 1, I_MULT, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10; i++)
            step("nonmd", 1, I_ADD, 0, 1, 0, (i == 0) ? 0 : 2, 0);
        step("nonmd_drop", 1, I_ADD, 0, 0, 0, 2, 0);
        step("nonmd_idle", 1, I_ADD, 0, 0, 0, 0, 0);

        // counter hits 17 at the edge closing busy cycle 17
        for (int i = 0; i < 20; i++)
            step("wdog", 1, I_MULT, 0, 1, 1, (i == 0) ? 0 : 2, (i >= 18) ? 1 : 0);
        step("wdog_drop",  1, I_MULT, 0, 0, 0, 2, 1);
        step("wdog_hold0", 1, I_MULT, 0, 0, 0, 0, 1);
        step("wdog_hold1", 1, I_MULT, 0, 0, 0, 0, 1);

        step("mid_busy", 1, I_MULT, 0, 1, 1, 0, 1);
        step("mid_rst",  0, I_MULT, 1, 1, 0, 2, 1);
        step("post_rst", 1, I_MULT, 0, 0, 0, 0, 0);

        step("both",        1, I_DIV, 1, 1, 1, 0, 0);
        step("both_busy",   1, I_DIV, 0, 1, 1, 2, 0);
        step("busy_to_iss", 1, I_DIV, 1, 0, 1, 2, 0);
        step("iss",         1, I_DIV, 0, 0, 1, 1, 0);
        step("iss_idle",    1, I_DIV, 0, 0, 0, 0, 0);

        step("st_rst", 0, I_MFLO, 0, 0, 0, 0, 0);
        step("st_clr", 1, I_MFLO, 0, 0, 0, 0, 0, 0, 0);
        for (int op = 0; op < 2; op++) begin
            step("st_start", 1, I_MFLO, 1, 0, 1, 0, 0);
            for (int i = 0; i < 10; i++)
                step("st_busy", 1, I_MFLO, 0, 1, 1, (i == 0) ? 1 : 2, 0);
            step("st_drop", 1, I_MFLO, 0, 0, 0, 2, 0, 11 * (op + 1), op + 1);
        end
        step("st_end", 1, I_MFLO, 0, 0, 0, 0, 0, 22, 2);

        for (int g = 0; g < 10 && q.size() > 0; g++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
